// File: rtl/btb_update_unit_if.sv
// Update port between the execute stage and the BTB update unit.
// The execute stage presents one resolved branch per handshake.
interface btb_update_unit_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  // Execute stage side: offers resolved branches.
  modport master (
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    input  upd_ready
  );

  // Update unit side: accepts resolved branches into its FIFO.
  modport slave (
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    output upd_ready
  );
endinterface

// File: rtl/btb_update_unit.sv
// BTB update unit: queues resolved-branch updates and applies each one to
// the tag/valid/counter/target arrays with a two-cycle read-modify-write.
// It is the only writer of those arrays; fetch reads them independently.
module btb_update_unit #(
  parameter  int bits  = 5,
  parameter  int depth = 4,
  localparam int tw    = 30 - bits
) (
  input  logic            clk,
  input  logic            rst,
  btb_update_unit_if.slave upd,
  output logic [bits-1:0] rd_index,
  input  logic [tw-1:0]   rd_tag,
  input  logic            rd_valid,
  input  logic [1:0]      rd_cnt,
  output logic [bits-1:0] wr_index,
  output logic            wr_load_meta,
  output logic            wr_load_target,
  output logic [tw-1:0]   wr_tag,
  output logic            wr_valid,
  output logic [1:0]      wr_cnt,
  output logic [31:0]     wr_target,
  output logic            busy
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  // PCs are word aligned, so only pc[31:2] is kept.
  typedef struct packed {
    logic [29:0] pc_w;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t          mem_q [depth];
  logic [aw-1:0]   wr_ptr_q, wr_ptr_d;
  logic [aw-1:0]   rd_ptr_q, rd_ptr_d;
  logic [cw-1:0]   count_q, count_d;
  logic            ready_q, ready_d;
  state_t          state_q, state_d;
  logic            hit_q, hit_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            push;
  logic            pop;
  entry_t          head;
  logic [bits-1:0] head_index;
  logic [tw-1:0]   head_tag;
  logic [cw-1:0]   count_after_pop;
  logic [1:0]      cnt_inc;
  logic [1:0]      cnt_dec;
  logic            unused_pc_offset;

  // The byte offset carries no index or tag information.
  assign unused_pc_offset = ^upd.upd_pc[1:0];

  // upd_ready comes straight from a flop so it is 0 throughout reset and
  // never depends on upd_valid.
  assign upd.upd_ready = ready_q;
  assign push          = upd.upd_valid && ready_q;
  assign pop           = (state_q == WR);
  assign busy          = (count_q != '0) || (state_q != IDLE);

  assign head       = mem_q[rd_ptr_q];
  assign head_index = head.pc_w[bits-1:0];
  assign head_tag   = head.pc_w[29:bits];

  // Occupancy once the WR pop (and any same-cycle push) has taken effect.
  assign count_after_pop = count_q - cw'(1) + cw'(push);

  // 2-bit counters saturate at both ends.
  assign cnt_inc = (cnt_q == 2'b11) ? 2'b11 : cnt_q + 2'b01;
  assign cnt_dec = (cnt_q == 2'b00) ? 2'b00 : cnt_q - 2'b01;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + cw'(push) - cw'(pop);
    if (push) wr_ptr_d = wr_ptr_q + aw'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + aw'(1);
    ready_d = (count_d != cw'(depth));
  end

  // FIFO storage write on an accepted update.
  // NOTE: the storage array has no reset; an entry is only read after it
  // was written, and the count (which is reset) decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc_w:   upd.upd_pc[31:2],
                           taken:  upd.upd_taken,
                           target: upd.upd_target};
    end
  end

  // FSM next-state, read-side capture and array write controls.
  always_comb begin
    state_d        = state_q;
    hit_d          = hit_q;
    cnt_d          = cnt_q;
    rd_index       = '0;
    wr_index       = '0;
    wr_load_meta   = 1'b0;
    wr_load_target = 1'b0;
    wr_tag         = '0;
    wr_valid       = 1'b0;
    wr_cnt         = 2'b00;
    wr_target      = '0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = RD;
      end

      RD: begin
        rd_index = head_index;
        hit_d    = rd_valid && (rd_tag == head_tag);
        cnt_d    = rd_cnt;
        state_d  = WR;
      end

      WR: begin
        wr_index  = head_index;
        wr_tag    = head_tag;
        wr_target = head.target;
        if (head.taken) begin
          // Taken: strengthen a hit, or allocate weakly-taken on a miss.
          wr_load_meta   = 1'b1;
          wr_load_target = 1'b1;
          wr_valid       = 1'b1;
          wr_cnt         = hit_q ? cnt_inc : 2'b10;
        end else if (hit_q) begin
          // Not taken on a hit: weaken, keep the stored target.
          wr_load_meta = 1'b1;
          wr_valid     = 1'b1;
          wr_cnt       = cnt_dec;
        end
        // Not taken on a miss: nothing is allocated, the entry just pops.
        state_d = (count_after_pop != '0) ? RD : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset empties the FIFO and drops any in-flight update.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: flops are updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      hit_q    <= 1'b0;
      cnt_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      hit_q    <= hit_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/btb_update_unit.md
# btb_update_unit

Write-side controller for the branch target buffer arrays. It accepts resolved-branch updates from the execute stage into a small FIFO and drains them one at a time. Each drain performs a two-cycle read-modify-write of the tag, valid, target and 2-bit counter arrays, while fetch continues to read those arrays independently. It is the only agent that drives the arrays' `load`/`windex`/`datain` pins.

## Interface

Parameters:
- `bits`, 5: BTB index width; the array holds 2**bits entries.
- `depth`, 4: update FIFO entries; must be a power of two and at least 2.
- Derived: `tw = 30 - bits`, the tag width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `upd_valid`  in  1  execute stage presents a resolved branch.
- `upd_ready`  out  1  FIFO can accept an update (`!full`).
- `upd_pc`  in  32  branch PC; index = `pc[bits+1:2]`, tag = `pc[31:bits+2]`.
- `upd_taken`  in  1  resolved direction.
- `upd_target`  in  32  resolved target; meaningful only when taken.
- `rd_index`  out  bits  read index into the update-side read port of the tag, valid and counter arrays.
- `rd_tag`  in  tw  tag at `rd_index`.
- `rd_valid`  in  1  valid bit at `rd_index`.
- `rd_cnt`  in  2  counter at `rd_index`.
- `wr_index`  out  bits  write index for all arrays.
- `wr_load_meta`  out  1  write enable for the tag, valid and counter arrays.
- `wr_load_target`  out  1  write enable for the target array.
- `wr_tag`  out  tw  tag write data.
- `wr_valid`  out  1  valid write data.
- `wr_cnt`  out  2  counter write data.
- `wr_target`  out  32  target write data.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation

FIFO behaviour:
- A push occurs when `upd_valid && upd_ready`; the entry stores `{pc, taken, target}`.
- A pop occurs only in state WR.
- Push and pop may occur in the same cycle; the count is then unchanged.
- Pointers wrap modulo `depth`; a `log2(depth)+1`-bit count distinguishes full from empty.
- A push attempted while full cannot occur, because `upd_ready` is low.

FSM states:
- IDLE: go to RD when count != 0.
- RD:
  - Drive `rd_index` with the head entry's index; the arrays read combinationally.
  - Register `hit = rd_valid && (rd_tag == head tag)` and register `rd_cnt`.
  - Go to WR.
- WR:
  - Compute the write from the registered values and the head entry (rules below).
  - Pop the head.
  - Go to RD if count after the pop != 0, otherwise go to IDLE.

WR write rules:
- Taken, hit: `wr_load_meta = wr_load_target = 1`, `wr_cnt = min(cnt+1, 3)`, `wr_valid = 1`, tag and target from the entry.
- Taken, miss: allocate with both loads = 1, `wr_cnt = 2'b10`, `wr_valid = 1`.
- Not taken, hit: `wr_load_meta = 1`, `wr_load_target = 0`, `wr_cnt = max(cnt-1, 0)`, `wr_valid = 1`.
- Not taken, miss: both loads = 0 (no allocation); the entry is still popped.
- Counter arithmetic saturates at 0 and 3 and never wraps.

Outputs outside WR:
- Both loads are 0.
- Write data is don't-care; drive 0 in IDLE.

Ordering:
- Updates are applied in FIFO order.
- Back-to-back updates to the same index need no forwarding: the WR write lands at the clock edge before the next RD samples the arrays.

## Timing

- Reset (`rst` low, asynchronous):
  - FIFO empties and FSM goes to IDLE.
  - Every output is 0, including `upd_ready`.
  - `upd_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-operation discards all queued updates and the in-flight update; no partial write is issued.
- Latency: an update pushed at edge t reaches RD in cycle t+1 and WR in cycle t+2; the array holds the new value after edge t+3.
- Throughput: one update per two cycles while the FIFO is non-empty. Continuous input at one per cycle fills the FIFO, and `upd_ready` then deasserts.
- `upd_ready` depends only on registered state (the count), not on `upd_valid`.
- `busy` is 0 only in IDLE with an empty FIFO.

## Test plan

- Reset with `rst` low mid-drain (FIFO holding 3 entries):
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release: `upd_ready` = 1, `busy` = 0, no load pulses.
- Taken update `pc=0x0000_0040`, `target=0x0000_1000` on an empty entry:
  - Exactly one WR cycle with `wr_index=16`, both loads = 1, `wr_cnt=2`, `wr_valid=1`, `wr_target=0x1000`.
  - WR occurs two cycles after the push.
- Same PC taken three more times:
  - `wr_cnt` sequence is 3, 3, 3 (saturates).
  - Then four not-taken updates give 2, 1, 0, 0, each with `wr_load_target=0`.
- Not-taken update to an index with a mismatched tag (or `valid=0`):
  - No load asserted.
  - Entry popped; FSM returns to IDLE.
- Push 6 updates on consecutive cycles with `depth=4`:
  - `upd_ready` drops when 4 entries are queued.
  - All accepted updates are written in order, at one per two cycles.
  - `busy` falls after the final WR.
- Two back-to-back taken updates to the same index with different tags:
  - Second RD sees the first write.
  - Registered `hit` = 0, so the second update allocates with `wr_cnt=2` and the new tag.
